team_06_adc_capture_ctrl: RTL
=============================

# team_06_adc_capture_ctrl

Controller that sequences the 8-bit serial ADC capture path. It drives ADC chip-select and serial clock, shifts in MSB-first bits, and pushes each completed sample into a 2-entry output FIFO with a valid/ready handshake toward the I2S/DSP side. Frames repeat automatically while `enable` is high. The block owns frame timing, so downstream logic never counts bits.

## Interface

Parameters:
- `CLK_DIV`, default 4: `clk` cycles per `adc_sclk` half-period; must be at least 2.
- `FRAME_GAP`, default 2: `clk` cycles with `adc_cs_n` high between frames; must be at least 1.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run continuous capture frames.
- `adc_serial_in` in 1: ADC data bit, MSB first.
- `adc_sclk` out 1: serial clock to ADC; idles low.
- `adc_cs_n` out 1: ADC chip select, active low.
- `sample_data` out 8: FIFO head sample.
- `sample_valid` out 1: FIFO non-empty.
- `sample_ready` in 1: consumer accepts the head when `sample_valid && sample_ready`.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky flag; a sample was dropped because the FIFO was full.

## Operation

- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=0.
  - `sample_data`=0x00, `sample_valid`=0.
  - `busy`=0, `overrun`=0.
  - FIFO empty; FSM in IDLE; divider and bit counters at 0.
- FSM states:
  - IDLE: `adc_cs_n`=1. Moves to SETUP on the edge that samples `enable`=1.
  - SETUP: `adc_cs_n`=0, `adc_sclk`=0 for `CLK_DIV` cycles, then SHIFT.
  - SHIFT: the divider toggles `adc_sclk` every `CLK_DIV` cycles, starting with a low half.
    - On the edge that drives `adc_sclk` 0→1, `adc_serial_in` is captured: `shreg <= {shreg[6:0], adc_serial_in}` and `bit_cnt` increments.
    - After the 8th high half ends (`adc_sclk` back to 0), go to STORE.
    - Total time in SHIFT is 16×`CLK_DIV` cycles.
  - STORE: 1 cycle, `adc_cs_n`=1. `shreg` is pushed into the FIFO, then GAP.
  - GAP: `adc_cs_n`=1 for `FRAME_GAP` cycles. Then SETUP if `enable`=1, else IDLE.
- `enable` deasserted mid-frame: the current frame completes and its sample is stored; the FSM then returns to IDLE via GAP.
- `rst` mid-frame: on the next edge all state returns to reset values, the FIFO is flushed and the partial sample is discarded.
- FIFO:
  - Depth 2; `sample_data` is registered from the head entry.
  - Pop occurs on `sample_valid && sample_ready`.
- FIFO boundary conditions:
  - Push while full with no pop: the new sample is dropped, the FIFO is unchanged and the overrun path fires (see Configuration).
  - Push and pop in the same cycle while full: both are accepted, occupancy stays 2 and no overrun occurs.
  - Push and pop in the same cycle with occupancy 1: the head advances to the new sample and occupancy stays 1.
  - Pop while empty is ignored.

## Timing

- Frame period = `CLK_DIV` + 16×`CLK_DIV` + 1 + `FRAME_GAP` cycles; 71 at the defaults.
- The first STORE occurs 69 cycles after the edge that samples `enable` (defaults).
- `sample_valid` rises on the edge after STORE when the FIFO was empty, i.e. 70 edges after `enable` is sampled.
- `adc_sclk` and `adc_cs_n` are registered outputs.
- `adc_cs_n` falls on the IDLE→SETUP (or GAP→SETUP) edge.
- `adc_serial_in` must be stable for 1 `clk` cycle before each rising `adc_sclk` edge; the ADC shifts on the falling edge.
- `busy` is registered and equals (state != IDLE).

## Configuration

- `TEAM06_ADC_OVERRUN_EN` defined:
  - `overrun` is set on any dropped push and stays high until `rst`.
  - Additionally, while `overrun`=1 the FSM does not start new frames after the current GAP; it holds in IDLE with `busy`=0.
- Not defined:
  - `overrun` is tied to 0.
  - Dropped samples are silently discarded and capture continues uninterrupted.

## Test plan

- Reset, `enable`=1, ADC model drives 0xA7 (1010_0111) MSB first with defaults, `sample_ready`=1 → `sample_valid` pulses 70 edges after `enable` is sampled with `sample_data`=0xA7; exactly 16 `adc_sclk` edges while `adc_cs_n`=0.
- Back-to-back frames 0xD6, 0x3C, 0x81 with `sample_ready`=1 → samples appear in order, spaced 71 cycles apart; `adc_cs_n` is high for 3 cycles (STORE + GAP) between frames.
- `sample_ready`=0 for 3 frames (0x11, 0x22, 0x33) → FIFO holds 0x11, 0x22. With `TEAM06_ADC_OVERRUN_EN`: `overrun`=1 and `busy`=0 after the third frame. Without the macro: `overrun`=0 and capture continues. Releasing `sample_ready` then yields 0x11, then 0x22.
- FIFO full with `sample_ready`=1 on the STORE cycle → no overrun, occupancy stays 2, output order preserved.
- `enable` dropped during bit 3 of a frame carrying 0x5A → frame completes, 0x5A is delivered, FSM reaches IDLE, `busy`=0, `adc_cs_n`=1.
- `rst` asserted during bit 5 → the next edge gives `adc_cs_n`=1, `adc_sclk`=0, `sample_valid`=0; FIFO empty; no partial sample is ever output.

Source files
------------

// File: rtl/team_06_adc_capture_ctrl.sv
`timescale 1ns/1ps
// team_06_adc_capture_ctrl
// Runs repeating 8-bit serial ADC capture frames. It drives chip select and the
// serial clock and shifts in the data MSB first. Each completed sample goes into
// a 2-entry FIFO that has a valid/ready handshake toward the consumer.
// Optional feature macro: TEAM06_ADC_OVERRUN_EN. When it is defined, dropped
// samples raise a sticky overrun flag, and the capture loop stops after the
// current frame.
module team_06_adc_capture_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       adc_serial_in,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int DATA_W  = 8;
  localparam int CNT_MAX = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(FRAME_GAP - 1);
  localparam logic [3:0]       BITS     = 4'(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STORE, GAP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                capture;

  // Completed sample waiting for its FIFO write on the edge after STORE
  logic                vld_p0;
  logic [DATA_W-1:0]   push_data_p0;

  // FIFO: sample_data is the head entry, tail holds the second entry
  logic [DATA_W-1:0]   tail;
  logic [1:0]          count;
  logic [1:0]          next_count;
  logic                pop;
  logic                room;
  logic                accept;
  logic                hold_start;
  logic                stop_at_gap;

  assign capture = (state == SHIFT) && (cnt == DIV_LAST) && !adc_sclk;
  assign pop     = sample_valid & sample_ready;
  assign room    = (count != 2'd2) | pop;
  assign accept  = vld_p0 & room;

`ifdef TEAM06_ADC_OVERRUN_EN
  logic drop;
  assign drop        = vld_p0 & ~room;
  assign hold_start  = overrun;
  // The drop is tested directly so that a one-cycle gap still sees it
  assign stop_at_gap = overrun | drop;

  // Sticky flag for a sample lost to a full FIFO; only reset clears it
  always_ff @(posedge clk) begin
    if (rst)       overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end
`else
  assign overrun     = 1'b0;
  assign hold_start  = 1'b0;
  assign stop_at_gap = 1'b0;
`endif

  // Frame sequencer: chip select, serial clock divider and bit counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      adc_sclk <= 1'b0;
      adc_cs_n <= 1'b1;
      busy     <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable && !hold_start) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            adc_sclk <= ~adc_sclk;
            if (!adc_sclk) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == BITS) begin
              state    <= STORE;
              adc_cs_n <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STORE: begin
          vld_p0 <= 1'b1;
          cnt    <= '0;
          state  <= GAP;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (enable && !stop_at_gap) begin
              state    <= SETUP;
              adc_cs_n <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Data path registers: shift register, pending sample, FIFO second entry
  always_ff @(posedge clk) begin
    if (capture)
      shreg <= {shreg[DATA_W-2:0], adc_serial_in};
    if (state == STORE)
      push_data_p0 <= shreg;
    if (accept && ((count == 2'd2 && pop) || (count == 2'd1 && !pop)))
      tail <= push_data_p0;
  end

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    next_count = count;
    if (accept && !pop)
      next_count = count + 2'd1;
    else if (!accept && pop)
      next_count = count - 2'd1;
  end

  // FIFO head and occupancy; a pop while empty never happens because pop needs sample_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= 2'd0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      if (pop) begin
        if (count == 2'd2)
          sample_data <= tail;
        else if (accept)
          sample_data <= push_data_p0;
      end else if (accept && count == 2'd0) begin
        sample_data <= push_data_p0;
      end
      count        <= next_count;
      sample_valid <= (next_count != 2'd0);
    end
  end

endmodule
